// File: rtl/wb_sram_ctrl_pkg.sv
// wb_sram_ctrl_pkg: shared Wishbone cycle/burst codes, FSM encoding and wait-counter width
package wb_sram_ctrl_pkg;
  localparam logic [2:0] CTI_INC    = 3'b010;
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;
  localparam int CNT_W = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_ERR
  } state_t;
endpackage

// File: rtl/wb_sram_ctrl_burst_adr.sv
// wb_sram_ctrl_burst_adr: combinational next burst address, linear or wrap4/8/16 by BTE
module wb_sram_ctrl_burst_adr
  import wb_sram_ctrl_pkg::*;
#(
  parameter int AW = 18
) (
  input  logic [AW-1:0] i_adr,
  input  logic [1:0]    i_bte,
  output logic [AW-1:0] o_adr
);
  logic [AW-1:0] w_mask;
  // bits inside the mask count, bits outside it hold; linear lets the whole word roll over
  always_comb begin
    w_mask = i_bte == BTE_LINEAR ? '1 :
             i_bte == BTE_WRAP4  ? AW'(3) :
             i_bte == BTE_WRAP8  ? AW'(7) :
             i_bte == BTE_WRAP16 ? AW'(15) : '1;
    o_adr  = (i_adr & ~w_mask) | ((i_adr + 1'b1) & w_mask);
  end
endmodule

// File: rtl/wb_sram_ctrl.sv
// wb_sram_ctrl: Wishbone B3 slave driving async SRAM; optional range check via WB_SRAM_RANGE_CHECK_EN
module wb_sram_ctrl
  import wb_sram_ctrl_pkg::*;
#(
  parameter int ADDRESS = 25,
  parameter int SRAM_AW = 18,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [2:0]         wb_cti_i,
  input  logic [1:0]         wb_bte_i,
  input  logic [ADDRESS-1:0] wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  output logic               wb_ack_o,
  output logic               wb_rty_o,
  output logic               wb_err_o,
  output logic [31:0]        wb_dat_o,
  output logic [3:0]         wb_sel_o,
  output logic               sram_ce_no,
  output logic               sram_oe_no,
  output logic               sram_we_no,
  output logic [3:0]         sram_be_no,
  output logic [SRAM_AW-1:0] sram_adr_o,
  output logic [31:0]        sram_dat_o,
  output logic               sram_dat_oe_o,
  input  logic [31:0]        sram_dat_i
);
  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic [SRAM_AW-1:0] r_adr, w_adr_nx;
  logic [3:0]         r_sel, r_sel_o;
  logic [31:0]        r_dat, r_dat_o;
  logic               r_ack, r_err, r_ce_n, r_oe_n, r_we_n, r_doe;
  logic               w_go, w_burst, w_rd_last, w_wr_last, w_oob, w_bad;
  logic               w_rd_ack, w_wr_ack, w_step;

  wb_sram_ctrl_burst_adr #(.AW(SRAM_AW)) u_burst_adr (
    .i_adr(r_adr),
    .i_bte(wb_bte_i),
    .o_adr(w_adr_nx)
  );

  assign w_go      = wb_cyc_i & wb_stb_i;
  assign w_burst   = w_go & (wb_cti_i == CTI_INC);
  assign w_rd_last = r_cnt == CNT_W'(RD_WAIT);
  assign w_wr_last = r_cnt == CNT_W'(WR_WAIT - 1);
  assign w_oob     = |(wb_adr_i >> SRAM_AW);
  assign w_rd_ack  = (r_state == S_RD) & w_go & w_rd_last;
  assign w_wr_ack  = (r_state == S_WR_PULSE) & w_wr_last & w_go;
  assign w_step    = (w_rd_ack | ((r_state == S_WR_HOLD) & r_ack)) & w_burst & ~w_bad;

`ifdef WB_SRAM_RANGE_CHECK_EN
  assign w_bad    = w_oob;
  assign wb_err_o = r_err;
`else
  logic w_unused;
  assign w_bad    = 1'b0;
  assign wb_err_o = 1'b0;
  assign w_unused = w_oob ^ r_err;
`endif

  // ack is gated by the live strobe so it can never show while stb is low
  assign wb_ack_o      = r_ack & w_go;
  assign wb_rty_o      = 1'b0;
  assign wb_dat_o      = r_dat_o;
  assign wb_sel_o      = r_sel_o;
  assign sram_ce_no    = r_ce_n;
  assign sram_oe_no    = r_oe_n;
  assign sram_we_no    = r_we_n;
  assign sram_be_no    = r_ce_n ? 4'hF : ~r_sel;
  assign sram_adr_o    = r_adr;
  assign sram_dat_o    = r_dat;
  assign sram_dat_oe_o = r_doe;

  // next state: once the WE pulse starts it always runs through hold, even if cyc drops
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:     if (w_go && !r_ack && !r_err) w_state_nx = w_bad ? S_ERR : wb_we_i ? S_WR_SETUP : S_RD;
      S_RD:       if (!w_go) w_state_nx = S_IDLE;
                  else if (w_rd_last) w_state_nx = !w_burst ? S_IDLE : w_bad ? S_ERR : S_RD;
      S_WR_SETUP: w_state_nx = wb_cyc_i ? S_WR_PULSE : S_IDLE;
      S_WR_PULSE: if (w_wr_last) w_state_nx = S_WR_HOLD;
      S_WR_HOLD:  w_state_nx = !(r_ack && w_burst) ? S_IDLE : w_bad ? S_ERR : S_WR_SETUP;
      default:    w_state_nx = S_IDLE;
    endcase
  end

  // state, wait counter, latched beat and registered strobes decoded from the next state
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_sel_o <= '0;
      r_dat_o <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_doe   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= (w_state_nx == r_state && !w_step) ? r_cnt + 1'b1 : '0;
      r_ack   <= w_rd_ack | w_wr_ack;
      r_err   <= r_state == S_ERR;
      r_ce_n  <= w_state_nx inside {S_IDLE, S_ERR};
      r_oe_n  <= w_state_nx != S_RD;
      r_we_n  <= w_state_nx != S_WR_PULSE;
      r_doe   <= w_state_nx inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
      if (r_state == S_IDLE && w_state_nx != S_IDLE) begin
        r_adr <= wb_adr_i[SRAM_AW-1:0];
        r_sel <= wb_sel_i;
        r_dat <= wb_dat_i;
      end
      if (w_step) r_adr <= w_adr_nx;
      if ((r_state == S_RD && w_go) || r_state == S_WR_SETUP) r_sel <= wb_sel_i;
      if (r_state == S_WR_SETUP) r_dat <= wb_dat_i;
      if (w_rd_ack) begin
        r_dat_o <= sram_dat_i;
        r_sel_o <= wb_sel_i;
      end
    end
  end
endmodule
